latch_bank_write_ctrl: RTL and testbench

//   Write-port sequencer and arbiter for a register bank built from level-sensitive D latches.

---
 rtl/latch_bank_write_ctrl_if.sv | 30 +++
 rtl/latch_bank_write_ctrl.sv | 148 ++++++++++++++
 tb/tb_latch_bank_write_ctrl.sv | 384 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/latch_bank_write_ctrl_if.sv
// Request/latch-bus bundle for the latch-bank write sequencer.
// master = requester side, slave = the sequencer.
interface latch_bank_write_ctrl_if #(
  parameter int NREQ = 2,
  parameter int AW   = 3,
  parameter int DW   = 8
);
  localparam int NW = 1 << AW;
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic [DW-1:0]      lat_d;
  logic [NW-1:0]      lat_en;
  logic               busy;
  logic               wr_done;
  logic [GW-1:0]      grant_id;

  modport master (
    output req_valid, req_addr, req_data,
    input  req_ready, lat_d, lat_en, busy, wr_done, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data,
    output req_ready, lat_d, lat_en, busy, wr_done, grant_id
  );
endinterface

// File: rtl/latch_bank_write_ctrl.sv
// Round-robin write sequencer for a D-latch register bank: data settles with all
// enables low, one enable pulses for EN_CYCLES, then closes while data is still held.
module latch_bank_write_ctrl #(
  parameter int NREQ      = 2,
  parameter int AW        = 3,
  parameter int DW        = 8,
  parameter int EN_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  latch_bank_write_ctrl_if.slave bus
);
  localparam int NW = 1 << AW;
  localparam int GW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;

  if (EN_CYCLES < 1) begin : g_bad_en_cycles
    $error("latch_bank_write_ctrl: EN_CYCLES must be >= 1");
  end
  if (NREQ < 1) begin : g_bad_nreq
    $error("latch_bank_write_ctrl: NREQ must be >= 1");
  end

  typedef enum logic [1:0] {IDLE, SETUP, OPEN, HOLD} state_e;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_req_t;

  wr_req_t [NREQ-1:0] req;

  for (genvar i = 0; i < NREQ; i++) begin : g_req
    assign req[i] = {bus.req_addr[i*AW +: AW], bus.req_data[i*DW +: DW]};
  end

  state_e        state_q, state_d;
  logic [GW-1:0] rr_ptr_q, rr_ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] lat_d_q, lat_d_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NW-1:0] lat_en_q, lat_en_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  logic            win_found;
  logic [GW-1:0]   win_id;
  logic [GW-1:0]   win_nxt;
  logic            accept;
  logic [NREQ-1:0] ready;

  // Rotating-priority search starting at rr_ptr.
  always_comb begin
    logic [GW-1:0] idx;
    win_found = 1'b0;
    win_id    = '0;
    idx       = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = GW'((int'(rr_ptr_q) + k) % NREQ);
      if (!win_found && bus.req_valid[idx]) begin
        win_found = 1'b1;
        win_id    = idx;
      end
    end
  end

  assign win_nxt = GW'((int'(win_id) + 1) % NREQ);
  assign accept  = (state_q == IDLE) && win_found;

  always_comb begin
    ready = '0;
    if (accept) ready[win_id] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    addr_d   = addr_q;
    lat_d_d  = lat_d_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d  = SETUP;
          rr_ptr_d = win_nxt;
          grant_d  = win_id;
          addr_d   = req[win_id].addr;
          lat_d_d  = req[win_id].data;
        end
      end
      SETUP: begin
        state_d = OPEN;
        cnt_d   = CW'(EN_CYCLES - 1);
      end
      OPEN: begin
        if (cnt_q == '0) state_d = HOLD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so they come straight off flops.
  always_comb begin
    lat_en_d = '0;
    if (state_d == OPEN) lat_en_d[addr_q] = 1'b1;
    busy_d = (state_d != IDLE);
    done_d = (state_d == HOLD);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      addr_q   <= '0;
      lat_d_q  <= '0;
      cnt_q    <= '0;
      lat_en_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      addr_q   <= addr_d;
      lat_d_q  <= lat_d_d;
      cnt_q    <= cnt_d;
      lat_en_q <= lat_en_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.lat_d     = lat_d_q;
  assign bus.lat_en    = lat_en_q;
  assign bus.busy      = busy_q;
  assign bus.wr_done   = done_q;
  assign bus.grant_id  = grant_q;

  a_en_onehot0: assert property (@(posedge clk) disable iff (!rst_n) $onehot0(lat_en_q));
  a_d_stable:   assert property (@(posedge clk) disable iff (!rst_n)
                                 (lat_en_q != '0) |=> $stable(lat_d_q));
endmodule

// File: tb/tb_latch_bank_write_ctrl.sv
// Bench for latch_bank_write_ctrl: directed scenarios plus random traffic checked
// against a latch-bank model and a round-robin grant model.
module tb_latch_bank_write_ctrl;
  localparam int NREQ = 2;
  localparam int AW   = 3;
  localparam int DW   = 8;
  localparam int NW   = 1 << AW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  latch_bank_write_ctrl_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) if1 ();
  latch_bank_write_ctrl_if #(.NREQ(NREQ), .AW(AW), .DW(DW)) if3 ();

  latch_bank_write_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW), .EN_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));
  latch_bank_write_ctrl #(.NREQ(NREQ), .AW(AW), .DW(DW), .EN_CYCLES(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(if3.slave));

  int tests = 0;
  int fails = 0;

  typedef struct {
    int            id;
    int            addr;
    logic [DW-1:0] data;
  } wr_t;

  wr_t           sb[$];
  logic [DW-1:0] bank [NW];
  logic [DW-1:0] prev_d = '0;

  // Latch-bank model: any open enable copies the shared bus into its word.
  always @(negedge clk) begin
    if (rst_n) begin
      if (if1.lat_en != '0) begin
        tests++;
        if ($countones(if1.lat_en) != 1 || if1.lat_d !== prev_d) begin
          fails++;
          $display("FAIL mon_en_window: en=%h d=%h, need one-hot en and d=%h", if1.lat_en, if1.lat_d, prev_d);
        end
        for (int i = 0; i < NW; i++) if (if1.lat_en[i]) bank[i] = if1.lat_d;
      end
      if (if1.wr_done) begin
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL mon_spurious_done: wr_done with no accepted write outstanding");
        end else begin
          wr_t w;
          w = sb.pop_front();
          if (bank[w.addr] !== w.data || int'(if1.grant_id) != w.id) begin
            fails++;
            $display("FAIL mon_landed: bank[%0d]=%h gid=%0d, need %h gid=%0d",
                     w.addr, bank[w.addr], if1.grant_id, w.data, w.id);
          end
        end
      end
    end
    prev_d = if1.lat_d;
  end

  task automatic clear_inputs();
    if1.req_valid = '0; if1.req_addr = '0; if1.req_data = '0;
    if3.req_valid = '0; if3.req_addr = '0; if3.req_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clear_inputs();
    sb.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic note_accept(input int id);
    wr_t w;
    w.id   = id;
    w.addr = int'(if1.req_addr[id*AW +: AW]);
    w.data = if1.req_data[id*DW +: DW];
    sb.push_back(w);
  endtask

  task automatic set_req1(input int id, input int a, input int d);
    if1.req_addr[id*AW +: AW] = AW'(a);
    if1.req_data[id*DW +: DW] = DW'(d);
  endtask

  task automatic test_reset();
    int n;
    rst_n = 1'b0;
    clear_inputs();
    sb.delete();
    #1;
    tests++;
    if ({if1.lat_en, if1.lat_d, if1.busy, if1.wr_done, if1.grant_id, if1.req_ready,
         if3.lat_en, if3.lat_d, if3.busy, if3.wr_done, if3.grant_id, if3.req_ready} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: en=%h d=%h busy=%b done=%b gid=%0d rdy=%b, need all 0",
               if1.lat_en, if1.lat_d, if1.busy, if1.wr_done, if1.grant_id, if1.req_ready);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (if1.req_ready !== '0 || if1.busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_no_valid: rdy=%b busy=%b, need 0 0", if1.req_ready, if1.busy);
    end
    // Start a write from requester 0, then pull reset while its enable is open.
    if1.req_valid = 2'b01; set_req1(0, 3, 8'h11);
    #1;
    tests++;
    if (if1.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL midopen_accept: rdy=%b, need 01", if1.req_ready);
    end
    note_accept(0);
    @(negedge clk); if1.req_valid = '0;
    n = 0;
    while (if1.lat_en == '0 && n < 5) begin @(negedge clk); n++; end
    tests++;
    if (n == 5) begin
      fails++;
      $display("FAIL midopen_timeout: lat_en never opened within 5 cycles");
    end
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    tests++;
    if (if1.lat_en !== '0 || if1.busy !== 1'b0) begin
      fails++;
      $display("FAIL midopen_async_clear: en=%h busy=%b, need 0 0 before next edge", if1.lat_en, if1.busy);
    end
    @(negedge clk); rst_n = 1'b1;
    n = 0;
    repeat (4) begin @(negedge clk); if (if1.wr_done) n++; end
    tests++;
    if (n != 0) begin
      fails++;
      $display("FAIL midopen_no_done: wr_done seen %0d times, need 0", n);
    end
    // Round-robin pointer must be back at 0 after the aborted write.
    if1.req_valid = 2'b11;
    #1;
    tests++;
    if (if1.req_ready !== 2'b01) begin
      fails++;
      $display("FAIL midopen_rrptr: rdy=%b, need 01", if1.req_ready);
    end
    if1.req_valid = '0;
  endtask

  task automatic test_single();
    do_reset();
    if1.req_valid = 2'b01; set_req1(0, 5, 8'hA5);
    #1;
    tests++;
    if (if1.req_ready !== 2'b01) begin
      fails++; $display("FAIL single_ready: rdy=%b, need 01", if1.req_ready);
    end
    note_accept(0);
    @(negedge clk); if1.req_valid = '0;
    tests++;
    if (if1.lat_d !== 8'hA5 || if1.lat_en !== 8'h00 || if1.busy !== 1'b1 || if1.req_ready !== 2'b00) begin
      fails++;
      $display("FAIL single_setup: d=%h en=%h busy=%b rdy=%b, need a5 00 1 00", if1.lat_d, if1.lat_en, if1.busy, if1.req_ready);
    end
    @(negedge clk);
    tests++;
    if (if1.lat_en !== 8'h20 || if1.lat_d !== 8'hA5 || if1.wr_done !== 1'b0) begin
      fails++;
      $display("FAIL single_open: en=%h d=%h done=%b, need 20 a5 0", if1.lat_en, if1.lat_d, if1.wr_done);
    end
    @(negedge clk);
    tests++;
    if (if1.lat_en !== 8'h00 || if1.wr_done !== 1'b1 || if1.lat_d !== 8'hA5 || if1.grant_id !== 1'b0) begin
      fails++;
      $display("FAIL single_hold: en=%h done=%b d=%h gid=%0d, need 00 1 a5 0", if1.lat_en, if1.wr_done, if1.lat_d, if1.grant_id);
    end
    @(negedge clk);
    tests++;
    if (if1.busy !== 1'b0 || if1.wr_done !== 1'b0 || if1.lat_d !== 8'hA5) begin
      fails++;
      $display("FAIL single_idle: busy=%b done=%b d=%h, need 0 0 a5", if1.busy, if1.wr_done, if1.lat_d);
    end
  endtask

  task automatic test_alternate();
    int grants = 0;
    int last   = 0;
    int cyc    = 0;
    do_reset();
    while (grants < 4 && cyc < 40) begin
      for (int i = 0; i < NREQ; i++) set_req1(i, int'($urandom_range(NW-1)), int'($urandom_range(255)));
      if1.req_valid = 2'b11;
      #1;
      if (if1.req_ready != '0) begin
        tests++;
        if (if1.req_ready !== NREQ'(1 << (grants % 2))) begin
          fails++;
          $display("FAIL alt_order: grant %0d rdy=%b, need %b", grants, if1.req_ready, NREQ'(1 << (grants % 2)));
        end
        if (grants > 0) begin
          tests++;
          if (cyc - last != 4) begin
            fails++; $display("FAIL alt_spacing: %0d cycles between grants, need 4", cyc - last);
          end
        end
        note_accept(if1.req_ready[1] ? 1 : 0);
        last = cyc;
        grants++;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (grants != 4) begin
      fails++; $display("FAIL alt_timeout: %0d grants, need 4", grants);
    end
    if1.req_valid = '0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_en3();
    logic [NW-1:0] en_s   [7];
    logic [DW-1:0] d_s    [7];
    logic          done_s [7];
    logic          busy_s [7];
    int ones, first, dn;
    do_reset();
    if3.req_valid = 2'b01;
    if3.req_addr[0 +: AW] = '0;
    if3.req_data[0 +: DW] = 8'hFF;
    #1;
    tests++;
    if (if3.req_ready !== 2'b01) begin
      fails++; $display("FAIL en3_ready: rdy=%b, need 01", if3.req_ready);
    end
    for (int k = 0; k < 7; k++) begin
      @(negedge clk);
      if (k == 0) if3.req_valid = '0;
      en_s[k] = if3.lat_en; d_s[k] = if3.lat_d; done_s[k] = if3.wr_done; busy_s[k] = if3.busy;
    end
    ones = 0; first = -1; dn = -1;
    for (int k = 0; k < 7; k++) begin
      if (en_s[k] == 8'h01) begin ones++; if (first < 0) first = k; end
      if (done_s[k] && dn < 0) dn = k;
    end
    tests++;
    if (ones != 3 || first != 1) begin
      fails++; $display("FAIL en3_window: en=01 for %0d cycles from slot %0d, need 3 from 1", ones, first);
    end
    tests++;
    if (dn != 4 || busy_s[5] !== 1'b0) begin
      fails++; $display("FAIL en3_done: wr_done at slot %0d busy5=%b, need slot 4 busy 0", dn, busy_s[5]);
    end
    for (int k = 0; k < 5; k++) begin
      tests++;
      if (d_s[k] !== 8'hFF) begin
        fails++; $display("FAIL en3_d_stable: slot %0d d=%h, need ff", k, d_s[k]);
      end
    end
  endtask

  task automatic test_capture();
    do_reset();
    if1.req_valid = 2'b10; set_req1(1, 2, 8'h3C);
    #1;
    tests++;
    if (if1.req_ready !== 2'b10) begin
      fails++; $display("FAIL cap_ready: rdy=%b, need 10", if1.req_ready);
    end
    note_accept(1);
    @(negedge clk); if1.req_valid = '0;
    @(negedge clk);
    if1.req_data[DW +: DW] = 8'hC3;
    set_req1(0, 2, 8'h77);
    tests++;
    if (if1.lat_en !== 8'h04 || if1.lat_d !== 8'h3C) begin
      fails++; $display("FAIL cap_open: en=%h d=%h, need 04 3c", if1.lat_en, if1.lat_d);
    end
    @(negedge clk);
    tests++;
    if (if1.lat_d !== 8'h3C || if1.wr_done !== 1'b1) begin
      fails++; $display("FAIL cap_hold: d=%h done=%b, need 3c 1", if1.lat_d, if1.wr_done);
    end
    @(negedge clk);
    tests++;
    if (bank[2] !== 8'h3C) begin
      fails++; $display("FAIL cap_bank: bank[2]=%h, need 3c", bank[2]);
    end
  endtask

  task automatic test_random();
    logic [NREQ-1:0] vld      = '0;
    logic [NREQ-1:0] exp_rdy;
    int              others [NREQ];
    int              exp_ptr  = 0;
    int              accepted = 0;
    int              cyc      = 0;
    int              last_id  = -1;
    do_reset();
    for (int i = 0; i < NREQ; i++) others[i] = 0;
    while (accepted < 1000 && cyc < 20000) begin
      if (last_id >= 0) begin vld[last_id] = 1'b0; others[last_id] = 0; last_id = -1; end
      for (int i = 0; i < NREQ; i++) begin
        if (!vld[i]) begin
          if ($urandom_range(1) == 0) begin
            vld[i] = 1'b1;
            set_req1(i, int'($urandom_range(NW-1)), int'($urandom_range(255)));
          end
        end else if ($urandom_range(15) == 0) begin
          vld[i] = 1'b0; others[i] = 0;
        end else if ($urandom_range(3) == 0) begin
          set_req1(i, int'($urandom_range(NW-1)), int'($urandom_range(255)));
        end
      end
      if1.req_valid = vld;
      #1;
      exp_rdy = '0;
      if (!if1.busy) begin
        for (int k = 0; k < NREQ; k++) begin
          int j;
          j = (exp_ptr + k) % NREQ;
          if (vld[j]) begin exp_rdy[j] = 1'b1; break; end
        end
      end
      tests++;
      if (if1.req_ready !== exp_rdy) begin
        fails++; $display("FAIL rand_grant: cycle %0d rdy=%b, need %b", cyc, if1.req_ready, exp_rdy);
      end
      if (exp_rdy != '0) begin
        int id;
        id = exp_rdy[1] ? 1 : 0;
        note_accept(id);
        accepted++;
        exp_ptr = (id + 1) % NREQ;
        for (int j = 0; j < NREQ; j++) begin
          if (j != id && vld[j]) begin
            others[j]++;
            tests++;
            if (others[j] > NREQ - 1) begin
              fails++; $display("FAIL rand_starve: req %0d passed over %0d times, limit %0d", j, others[j], NREQ - 1);
            end
          end
        end
        last_id = id;
      end
      @(negedge clk);
      cyc++;
    end
    tests++;
    if (accepted < 1000) begin
      fails++; $display("FAIL rand_budget: %0d writes accepted, need 1000", accepted);
    end
    if1.req_valid = '0;
    repeat (6) @(negedge clk);
    tests++;
    if (sb.size() != 0) begin
      fails++; $display("FAIL rand_all_landed: %0d writes never completed, need 0", sb.size());
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < NW; i++) bank[i] = '0;
    clear_inputs();
    test_reset();
    test_single();
    test_alternate();
    test_en3();
    test_capture();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
